// File: rtl/maxi_test.sv
`default_nettype none
// ============================================================================
// Module   : maxi_test
// Brief    : AXI3 master: incrementing write bursts, read-back, pattern check.
//            Define MAXI_TEST_BACKPRESSURE_EN to LFSR-gate bready/rready.
// Revision : 1.0 - initial release
// ============================================================================
module maxi_test #(
  parameter int             MIDW      = 6,
  parameter int             MAW       = 32,
  parameter int             MDW       = 64,
  parameter int             MSTW      = 8,
  parameter logic [MAW-1:0] BASE_ADDR = '0,
  parameter int             NUM_TXN   = 16,
  parameter int             BURST_LEN = 4
) (
  input  logic            m_axi_aclk,
  input  logic            m_axi_aresetn,
  input  logic            START,
  output logic            ERROR,
  output logic            DONE,
  output logic [MIDW-1:0] m_axi_awid,
  output logic [MAW-1:0]  m_axi_awaddr,
  output logic [3:0]      m_axi_awlen,
  output logic [2:0]      m_axi_awsize,
  output logic [1:0]      m_axi_awburst,
  output logic [1:0]      m_axi_awlock,
  output logic [3:0]      m_axi_awcache,
  output logic [2:0]      m_axi_awprot,
  output logic [3:0]      m_axi_awqos,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [MIDW-1:0] m_axi_wid,
  output logic [MDW-1:0]  m_axi_wdata,
  output logic [MSTW-1:0] m_axi_wstrb,
  output logic            m_axi_wlast,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic [MIDW-1:0] m_axi_bid,
  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  output logic [MIDW-1:0] m_axi_arid,
  output logic [MAW-1:0]  m_axi_araddr,
  output logic [3:0]      m_axi_arlen,
  output logic [2:0]      m_axi_arsize,
  output logic [1:0]      m_axi_arburst,
  output logic [1:0]      m_axi_arlock,
  output logic [3:0]      m_axi_arcache,
  output logic [2:0]      m_axi_arprot,
  output logic [3:0]      m_axi_arqos,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  input  logic [MIDW-1:0] m_axi_rid,
  input  logic [MDW-1:0]  m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rlast,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready
);

  localparam logic [MAW-1:0] c_beat_bytes  = MAW'(MSTW);
  localparam logic [MAW-1:0] c_burst_bytes = MAW'(BURST_LEN * MSTW);
  localparam logic [4:0]     c_last_beat   = 5'(BURST_LEN - 1);
  localparam logic [8:0]     c_last_txn    = 9'(NUM_TXN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WADDR   = 3'd1,
    WDATA   = 3'd2,
    WRESP   = 3'd3,
    RADDR   = 3'd4,
    RDATA   = 3'd5,
    DONE_ST = 3'd6
  } state_t;

  // Even 32-bit lanes carry the byte address, odd lanes its complement.
  function automatic logic [MDW-1:0] pattern(input logic [MAW-1:0] addr);
    logic [31:0]    a32;
    logic [MDW-1:0] p;
    a32 = 32'(addr);
    p   = '0;
    for (int k = 0; k < MDW / 32; k++) begin
      p[k*32 +: 32] = (k % 2 == 0) ? a32 : ~a32;
    end
    return p;
  endfunction

  state_t          r_state;
  state_t          w_state_next;
  logic [8:0]      r_txn;
  logic [MIDW-1:0] r_id;
  logic [4:0]      r_beat;
  logic [MAW-1:0]  r_addr;
  logic [MAW-1:0]  r_beat_addr;
  logic [MDW-1:0]  r_wdata;
  logic            r_wlast;
  logic            r_awvalid;
  logic            r_wvalid;
  logic            r_bready;
  logic            r_arvalid;
  logic            r_rready;
  logic            r_error;
  logic            r_done;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_b_hs;
  logic            w_ar_hs;
  logic            w_r_hs;
  logic            w_last_beat;
  logic            w_last_txn;
  logic            w_b_err;
  logic            w_r_err;
  logic            w_bready_en;
  logic            w_rready_en;
  logic [4:0]      w_beat_next;
  logic [MAW-1:0]  w_beat_addr_next;

  assign w_aw_hs          = r_awvalid & m_axi_awready;
  assign w_w_hs           = r_wvalid  & m_axi_wready;
  assign w_b_hs           = r_bready  & m_axi_bvalid;
  assign w_ar_hs          = r_arvalid & m_axi_arready;
  assign w_r_hs           = r_rready  & m_axi_rvalid;
  assign w_last_beat      = (r_beat == c_last_beat);
  assign w_last_txn       = (r_txn == c_last_txn);
  assign w_beat_next      = w_last_beat ? 5'd0 : r_beat + 5'd1;
  assign w_beat_addr_next = r_beat_addr + c_beat_bytes;

  assign w_b_err = w_b_hs & ((m_axi_bresp != 2'b00) | (m_axi_bid != r_id));
  assign w_r_err = w_r_hs & ((m_axi_rdata != pattern(r_beat_addr)) |
                             (m_axi_rresp != 2'b00) |
                             (m_axi_rid != r_id) |
                             (m_axi_rlast != w_last_beat));

`ifdef MAXI_TEST_BACKPRESSURE_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  assign w_bready_en = w_lfsr_next[0];
  assign w_rready_en = w_lfsr_next[1];
`else
  assign w_bready_en = 1'b1;
  assign w_rready_en = 1'b1;
`endif

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (START) w_state_next = WADDR;
      WADDR:   if (w_aw_hs) w_state_next = WDATA;
      WDATA:   if (w_w_hs && w_last_beat) w_state_next = WRESP;
      WRESP:   if (w_b_hs) w_state_next = w_last_txn ? RADDR : WADDR;
      RADDR:   if (w_ar_hs) w_state_next = RDATA;
      RDATA:   if (w_r_hs && w_last_beat) w_state_next = w_last_txn ? DONE_ST : RADDR;
      DONE_ST: w_state_next = DONE_ST;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_txn       <= '0;
      r_id        <= '0;
      r_beat      <= '0;
      r_addr      <= BASE_ADDR;
      r_beat_addr <= BASE_ADDR;
      r_wdata     <= pattern(BASE_ADDR);
      r_wlast     <= (BURST_LEN == 1);
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_awvalid <= (w_state_next == WADDR);
      r_wvalid  <= (w_state_next == WDATA);
      r_bready  <= (w_state_next == WRESP) & w_bready_en;
      r_arvalid <= (w_state_next == RADDR);
      r_rready  <= (w_state_next == RDATA) & w_rready_en;
      r_error   <= r_error | w_b_err | w_r_err;
      r_done    <= r_done | (w_state_next == DONE_ST);

      if (w_w_hs || w_r_hs) begin
        r_beat      <= w_beat_next;
        r_beat_addr <= w_beat_addr_next;
        r_wdata     <= pattern(w_beat_addr_next);
        r_wlast     <= (w_beat_next == c_last_beat);
        if (w_r_hs && w_last_beat && !w_last_txn) begin
          r_txn  <= r_txn + 9'd1;
          r_id   <= r_id + MIDW'(1);
          r_addr <= r_addr + c_burst_bytes;
        end
      end else if (w_b_hs) begin
        if (w_last_txn) begin
          // Read-back restarts from the first burst.
          r_txn       <= '0;
          r_id        <= '0;
          r_addr      <= BASE_ADDR;
          r_beat_addr <= BASE_ADDR;
          r_wdata     <= pattern(BASE_ADDR);
        end else begin
          r_txn  <= r_txn + 9'd1;
          r_id   <= r_id + MIDW'(1);
          r_addr <= r_addr + c_burst_bytes;
        end
      end
    end
  end

  assign ERROR         = r_error;
  assign DONE          = r_done;

  assign m_axi_awid    = r_id;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 4'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(MSTW));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = r_awvalid;

  assign m_axi_wid     = r_id;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = r_wlast;
  assign m_axi_wvalid  = r_wvalid;

  assign m_axi_bready  = r_bready;

  assign m_axi_arid    = r_id;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = 4'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(MSTW));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = r_arvalid;

  assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire
